// File: rtl/fast_ann_io_pkg.sv
// fast_ann_io_pkg: shared geometry defaults and transmitter state type for the fast-ANN IO path
package fast_ann_io_pkg;
  localparam int TX_DATA_WIDTH = 11;
  localparam int TX_ROW_SIZE = 26;
  localparam int TX_COL_SIZE = 19;
  localparam int TX_BLOCKING = 4;
  localparam int TX_XB = (TX_ROW_SIZE / 2 + TX_BLOCKING - 1) / TX_BLOCKING;
  localparam int TX_TOTAL_WORDS = TX_ROW_SIZE * TX_COL_SIZE;
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} tx_state_t;
endpackage

// File: rtl/tx_skid_fifo.sv
// tx_skid_fifo: 2-entry synchronous FIFO with occupancy count; head always visible on dout
module tx_skid_fifo #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic rp, wp;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rp <= 1'b0;
      wp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= wp ^ push;
      rp <= rp ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/best_arr_io_tx.sv
// best_arr_io_tx: streams the best-index array to the host pins in blocked order (BEST_ARR_TX_LAST_EN adds out_last_o)
module best_arr_io_tx
  import fast_ann_io_pkg::*;
#(
  parameter int DATA_WIDTH = TX_DATA_WIDTH,
  parameter int ROW_SIZE = TX_ROW_SIZE,
  parameter int COL_SIZE = TX_COL_SIZE,
  parameter int BLOCKING = TX_BLOCKING,
  parameter int ADDR_WIDTH = $clog2(ROW_SIZE * COL_SIZE)
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  send_best_arr_i,
  output logic                  mem_ren_o,
  output logic [ADDR_WIDTH-1:0] mem_raddr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  out_rempty_n_o,
  output logic [DATA_WIDTH-1:0] out_rdata_o,
  input  logic                  out_deq_i,
  output logic                  busy_o,
`ifdef BEST_ARR_TX_LAST_EN
  output logic                  out_last_o,
`endif
  output logic                  done_o
);
  localparam int HALF = ROW_SIZE / 2;
  localparam int XB = (HALF + BLOCKING - 1) / BLOCKING;
  localparam int XW = XB > 1 ? $clog2(XB) : 1;
  localparam int YW = COL_SIZE > 1 ? $clog2(COL_SIZE) : 1;
  localparam int BW = BLOCKING > 1 ? $clog2(BLOCKING) : 1;
`ifdef BEST_ARR_TX_LAST_EN
  localparam int FW = DATA_WIDTH + 1;
`else
  localparam int FW = DATA_WIDTH;
`endif
  tx_state_t state_q, state_d;
  logic px;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [BW-1:0] xi;
  logic pend, pop, issue, start;
  logic xi_last, y_last, x_last, last_tuple;
  logic [1:0] count;
  logic [2:0] occ_next;
  logic [FW-1:0] fifo_din, fifo_dout;
  // xi_last also fires at the ragged edge of the last block so skipped tuples never cost a cycle
  assign xi_last = xi == BW'(BLOCKING - 1) || int'(x) * BLOCKING + int'(xi) + 1 >= HALF;
  assign y_last = y == YW'(COL_SIZE - 1);
  assign x_last = x == XW'(XB - 1);
  assign last_tuple = px && x_last && y_last && xi_last;
  assign start = state_q == IDLE && send_best_arr_i;
  assign pop = out_deq_i && count != 2'd0;
  // occupancy after this edge: counting the pop lets a read issue every cycle under full-rate dequeue
  assign occ_next = {1'b0, count} + {2'b0, pend} - {2'b0, pop};
  assign issue = state_q == SCAN && occ_next < 3'd2;
  assign mem_ren_o = issue;
  assign mem_raddr_o = ADDR_WIDTH'(int'(px) * HALF + int'(y) * ROW_SIZE + int'(x) * BLOCKING + int'(xi));
  assign out_rempty_n_o = count != 2'd0;
  assign out_rdata_o = fifo_dout[DATA_WIDTH-1:0];
  assign busy_o = state_q == SCAN || state_q == DRAIN;
  assign done_o = state_q == DONE;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      px <= 1'b0;
      x <= '0;
      y <= '0;
      xi <= '0;
    end else if (start) begin
      px <= 1'b0;
      x <= '0;
      y <= '0;
      xi <= '0;
    end else if (issue && !last_tuple) begin
      xi <= xi_last ? '0 : xi + BW'(1);
      y <= !xi_last ? y : y_last ? '0 : y + YW'(1);
      x <= !(xi_last && y_last) ? x : x_last ? '0 : x + XW'(1);
      px <= px ^ (xi_last && y_last && x_last);
    end
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      pend <= 1'b0;
    end else begin
      state_q <= state_d;
      pend <= issue;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = send_best_arr_i ? SCAN : IDLE;
      SCAN:  state_d = issue && last_tuple ? DRAIN : SCAN;
      DRAIN: state_d = occ_next == 3'd0 ? DONE : DRAIN;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
`ifdef BEST_ARR_TX_LAST_EN
  logic pend_last;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) pend_last <= 1'b0;
    else pend_last <= issue && last_tuple;
  end
  assign fifo_din = {pend_last, mem_rdata_i};
  assign out_last_o = out_rempty_n_o && fifo_dout[DATA_WIDTH];
`else
  assign fifo_din = mem_rdata_i;
`endif
  tx_skid_fifo #(.W(FW)) u_fifo (
    .clk(wb_clk_i),
    .rst(wb_rst_i),
    .push(pend),
    .din(fifo_din),
    .pop(pop),
    .dout(fifo_dout),
    .count(count)
  );
endmodule

// File: tb/tb_best_arr_io_tx.sv
// tb_best_arr_io_tx: scoreboard bench for best_arr_io_tx ordering, timing, backpressure and reset
module tb_best_arr_io_tx;
  import fast_ann_io_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic send = 1'b0;
  logic deq = 1'b0;
  logic deq_rand = 1'b0;
  logic mem_ren, rempty_n, busy, done;
  logic [8:0] raddr;
  logic [10:0] rdata_mem = '0;
  logic [10:0] rdata;
`ifdef BEST_ARR_TX_LAST_EN
  logic last;
`endif
  int n_vec = 0;
  int n_err = 0;
  int popped = 0;
  int done_cnt = 0;
  int m_occ = 0;
  int m_pend = 0;
  int cyc;
  logic [10:0] exp_q[$];
  int addr_q[$];
  logic prev_valid = 1'b0;
  logic prev_pop = 1'b0;
  logic [10:0] prev_data = '0;

  best_arr_io_tx dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .send_best_arr_i(send),
    .mem_ren_o(mem_ren),
    .mem_raddr_o(raddr),
    .mem_rdata_i(rdata_mem),
    .out_rempty_n_o(rempty_n),
    .out_rdata_o(rdata),
    .out_deq_i(deq),
    .busy_o(busy),
`ifdef BEST_ARR_TX_LAST_EN
    .out_last_o(last),
`endif
    .done_o(done)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] gold(input int a);
    return 11'((a * 5 + 3) & 32'h7FF);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) if (mem_ren) rdata_mem <= gold(int'(raddr));

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_occ <= 0;
      m_pend <= 0;
    end else begin
      m_occ <= m_occ + m_pend - int'(rempty_n && deq);
      m_pend <= int'(mem_ren);
    end
  end

  always @(negedge clk) begin
    if (rst) prev_valid <= 1'b0;
    else begin
      if (mem_ren) begin
        addr_q.push_back(int'(raddr));
        chk("ren_room", 32'(m_occ + m_pend - int'(rempty_n && deq) < 2), 1);
      end
      if (prev_valid && !prev_pop && rempty_n) chk("hold", rdata, prev_data);
      if (rempty_n && deq) begin
        if (exp_q.size() == 0) chk("extra_pop", 1, 0);
        else chk("word", rdata, exp_q.pop_front());
`ifdef BEST_ARR_TX_LAST_EN
        chk("last", last, 32'(exp_q.size() == 0));
`endif
        popped++;
      end
      if (done) begin
        chk("done_after_last", popped, TX_TOTAL_WORDS);
        done_cnt++;
      end
      prev_valid <= rempty_n;
      prev_pop <= rempty_n && deq;
      prev_data <= rdata;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (deq_rand) deq = $urandom_range(0, 99) < 30;
  end

  task automatic start_run;
    exp_q.delete();
    addr_q.delete();
    popped = 0;
    done_cnt = 0;
    for (int p = 0; p < 2; p++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 19; y++)
          for (int xi = 0; xi < 4; xi++)
            if (x * 4 + xi < 13) exp_q.push_back(gold(p * 13 + y * 26 + x * 4 + xi));
    @(posedge clk) #1 send = 1'b1;
    @(posedge clk) #1 send = 1'b0;
    chk("ren_after_start", mem_ren, 1);
    chk("addr_first", raddr, 0);
    chk("busy_start", busy, 1);
  endtask

  task automatic wait_done(input int budget, output int c);
    c = 0;
    while (!done && c < budget) begin
      @(posedge clk) #1;
      c++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ren"}, mem_ren, 0);
    chk({tag, "_addr"}, raddr, 0);
    chk({tag, "_valid"}, rempty_n, 0);
    chk({tag, "_data"}, rdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef BEST_ARR_TX_LAST_EN
    chk({tag, "_last"}, last, 0);
`endif
  endtask

  initial begin
    int exp_a[8] = '{0, 1, 2, 3, 26, 27, 28, 29};
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    deq = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_deq_valid", rempty_n, 0);
    chk("idle_deq_busy", busy, 0);

    start_run();
    @(posedge clk) #1 chk("valid_e1", rempty_n, 0);
    @(posedge clk) #1 chk("valid_e2", rempty_n, 1);
    wait_done(2000, cyc);
    chk("contig_cycles", cyc + 2, 496);
    chk("run1_count", popped, TX_TOTAL_WORDS);
    chk("run1_left", exp_q.size(), 0);
    chk("addr_total", addr_q.size(), TX_TOTAL_WORDS);
    if (addr_q.size() == TX_TOTAL_WORDS) begin
      for (int i = 0; i < 8; i++) chk("addr_head", addr_q[i], exp_a[i]);
      chk("addr_x3_y0", addr_q[228], 12);
      chk("addr_x3_y1", addr_q[229], 38);
      chk("addr_px1", addr_q[247], 13);
      chk("addr_final", addr_q[493], 493);
    end
    @(posedge clk) #1;
    chk("done_pulse_end", done, 0);
    chk("run1_done_cnt", done_cnt, 1);
    chk("run1_busy_end", busy, 0);

    deq_rand = 1'b1;
    start_run();
    fork
      wait_done(8000, cyc);
      begin
        int t = 0;
        while (popped < 100 && t < 8000) begin
          @(posedge clk) #1;
          t++;
        end
        send = 1'b1;
        @(posedge clk) #1 send = 1'b0;
      end
    join
    deq_rand = 1'b0;
    deq = 1'b0;
    chk("run2_count", popped, TX_TOTAL_WORDS);
    chk("run2_left", exp_q.size(), 0);
    @(posedge clk) #1;
    chk("run2_busy_end", busy, 0);
    chk("run2_done_cnt", done_cnt, 1);
    repeat (3) @(posedge clk);
    #1 chk("run2_no_restart", busy, 0);

    deq = 1'b1;
    start_run();
    cyc = 0;
    while (popped < 250 && cyc < 2000) begin
      @(posedge clk) #1;
      cyc++;
    end
    chk("reached_250", 32'(popped >= 250), 1);
    @(posedge clk) #1 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    start_run();
    wait_done(2000, cyc);
    chk("run4_count", popped, TX_TOTAL_WORDS);
    chk("run4_left", exp_q.size(), 0);
    if (addr_q.size() > 0) chk("run4_addr0", addr_q[0], 0);
    else chk("run4_addr0_seen", 0, 1);
    @(posedge clk) #1;
    chk("run4_done_cnt", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
